// File: rtl/bpred_ctrl.sv
// Branch direction predictor with in-flight branch queue for the IF stage.
// Define BPRED_BHT_EN for a PC-indexed counter table; otherwise one global counter.
module bpred_ctrl #(
    parameter int unsigned QUE_DEPTH   = 2,
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned data_size   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [data_size-1:0] PC_IF,
    input  logic [data_size-1:0] imm_IF,
    input  logic [6:0]           opcode_IF,
    input  logic [6:0]           opcode_EXE,
    input  logic                 branch_taken_EXE,
    input  logic                 Istall,
    input  logic                 Dstall,
    input  logic                 flush,
    output logic                 taken_sel,
    output logic                 jump_sel,
    output logic [data_size-1:0] PC_imm,
    output logic [data_size-1:0] PC_imm_que,
    output logic                 que_empty,
    output logic                 mispredict
);

    localparam logic [6:0] BTYPE = 7'b1100011;
    localparam logic [6:0] JTYPE = 7'b1101111;
    localparam int unsigned PW   = $clog2(QUE_DEPTH);

    logic                 r_que_pred [QUE_DEPTH];
    logic [data_size-1:0] r_que_alt  [QUE_DEPTH];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [PW:0]          r_count;

    logic                 w_stall;
    logic                 w_btype_if;
    logic                 w_btype_exe;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_if_ctr;
    logic [data_size-1:0] w_alt_pc;

    function automatic logic [1:0] f_train(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? c : c + 2'd1;
        else   return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    assign w_stall     = Istall | Dstall;
    assign w_btype_if  = (opcode_IF == BTYPE);
    assign w_btype_exe = (opcode_EXE == BTYPE);
    assign w_full      = (r_count == (PW+1)'(QUE_DEPTH));
    assign que_empty   = (r_count == '0);

    assign PC_imm      = PC_IF + imm_IF;
    assign taken_sel   = (opcode_IF == JTYPE) ? 1'b1 : (w_btype_if ? w_if_ctr[1] : 1'b0);
    assign w_alt_pc    = taken_sel ? PC_IF + data_size'(4) : PC_imm;

    // A full queue still accepts a push when the head pops in the same cycle.
    assign w_pop       = w_btype_exe & ~w_stall & ~que_empty;
    assign w_push      = w_btype_if & ~w_stall & ~flush & (~w_full | w_pop);

    assign jump_sel    = w_btype_exe & branch_taken_EXE;
    assign mispredict  = w_btype_exe & ~que_empty & (branch_taken_EXE != r_que_pred[r_head]);
    assign PC_imm_que  = que_empty ? '0 : r_que_alt[r_head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_que_pred <= '{default: 1'b0};
            r_que_alt  <= '{default: '0};
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_que_pred[r_tail] <= taken_sel;
                r_que_alt[r_tail]  <= w_alt_pc;
            end
            // Flush squashes every younger branch; the head's pop has already trained.
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + PW'(1);
                if (w_pop)  r_head <= r_head + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PW+1)'(1);
                    2'b01:   r_count <= r_count - (PW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef BPRED_BHT_EN
    localparam int unsigned IW = $clog2(BHT_ENTRIES);

    logic [1:0]    r_bht     [BHT_ENTRIES];
    logic [IW-1:0] r_que_idx [QUE_DEPTH];
    logic [IW-1:0] w_if_idx;

    assign w_if_idx = PC_IF[IW+1:2];
    assign w_if_ctr = r_bht[w_if_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bht     <= '{default: 2'b01};
            r_que_idx <= '{default: '0};
        end else begin
            if (w_push) r_que_idx[r_tail] <= w_if_idx;
            if (w_pop)  r_bht[r_que_idx[r_head]] <= f_train(r_bht[r_que_idx[r_head]], branch_taken_EXE);
        end
    end
`else
    logic [1:0] r_gctr;

    assign w_if_ctr = r_gctr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gctr <= 2'b01;
        end else if (w_pop) begin
            r_gctr <= f_train(r_gctr, branch_taken_EXE);
        end
    end
`endif

endmodule

// File: tb/tb_bpred_ctrl.sv
// Directed table-driven bench for bpred_ctrl (default build: single global counter).
module tb_bpred_ctrl;

    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;
    localparam logic [6:0] OP_N = 7'b0010011;

    logic        clk;
    logic        rst_n;
    logic [31:0] PC_IF;
    logic [31:0] imm_IF;
    logic [6:0]  opcode_IF;
    logic [6:0]  opcode_EXE;
    logic        branch_taken_EXE;
    logic        Istall;
    logic        Dstall;
    logic        flush;
    logic        taken_sel;
    logic        jump_sel;
    logic [31:0] PC_imm;
    logic [31:0] PC_imm_que;
    logic        que_empty;
    logic        mispredict;

    bpred_ctrl #(.QUE_DEPTH(2), .BHT_ENTRIES(16), .data_size(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PC_IF            (PC_IF),
        .imm_IF           (imm_IF),
        .opcode_IF        (opcode_IF),
        .opcode_EXE       (opcode_EXE),
        .branch_taken_EXE (branch_taken_EXE),
        .Istall           (Istall),
        .Dstall           (Dstall),
        .flush            (flush),
        .taken_sel        (taken_sel),
        .jump_sel         (jump_sel),
        .PC_imm           (PC_imm),
        .PC_imm_que       (PC_imm_que),
        .que_empty        (que_empty),
        .mispredict       (mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [6:0]  op_if;
        logic [6:0]  op_exe;
        logic        tk;
        logic        ist;
        logic        dst;
        logic        fl;
        logic        e_ts;
        logic        e_js;
        logic [31:0] e_pcimm;
        logic [31:0] e_que;
        logic        e_empty;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] imm,
                                input logic [6:0] oi, input logic [6:0] oe,
                                input logic tk, input logic ist, input logic dst, input logic fl,
                                input logic ets, input logic ejs,
                                input logic [31:0] epi, input logic [31:0] eq,
                                input logic eem, input logic emi);
        vec_t v;
        v.pc = pc; v.imm = imm; v.op_if = oi; v.op_exe = oe;
        v.tk = tk; v.ist = ist; v.dst = dst; v.fl = fl;
        v.e_ts = ets; v.e_js = ejs; v.e_pcimm = epi; v.e_que = eq;
        v.e_empty = eem; v.e_mis = emi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] imm,
                         input logic [6:0] oi, input logic [6:0] oe,
                         input logic tk, input logic ist, input logic dst, input logic fl);
        PC_IF = pc; imm_IF = imm; opcode_IF = oi; opcode_EXE = oe;
        branch_taken_EXE = tk; Istall = ist; Dstall = dst; flush = fl;
    endtask

    // Independent occupancy tracker: a push while full with no pop must never happen.
    int   occ;
    logic m_push_req;
    logic m_pop;
    assign m_push_req = (opcode_IF == OP_B) && !(Istall || Dstall) && !flush;
    assign m_pop      = (opcode_EXE == OP_B) && !(Istall || Dstall) && (occ != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= 0;
        end else begin
            if (m_push_req && !m_pop && occ == 2) begin
                n_fail++;
                $display("FAIL queue_overflow: push while full, occupancy %0d limit 2", occ);
            end
            if (flush)                                     occ <= 0;
            else if (m_push_req && !m_pop && occ < 2)      occ <= occ + 1;
            else if (!m_push_req && m_pop)                 occ <= occ - 1;
        end
    end

    initial begin
        //          pc          imm         if    exe   tk  ist dst fl  ts  js  pc_imm      que         emp mis
        vecs.push_back(mk(32'h100, 32'h40,  OP_N, OP_N, 0,  0,  0,  0,  0,  0,  32'h140, 32'h0,   1,  0)); // reset state
        vecs.push_back(mk(32'h100, 32'h40,  OP_B, OP_N, 0,  0,  0,  0,  0,  0,  32'h140, 32'h0,   1,  0)); // weak-NT, push 0x140
        vecs.push_back(mk(32'h200, 32'h10,  OP_N, OP_N, 0,  0,  0,  0,  0,  0,  32'h210, 32'h140, 0,  0));
        vecs.push_back(mk(32'h100, 32'h40,  OP_N, OP_B, 1,  0,  0,  0,  0,  1,  32'h140, 32'h140, 0,  1)); // resolve taken: 01->10
        vecs.push_back(mk(32'h100, 32'h40,  OP_B, OP_N, 0,  0,  0,  0,  1,  0,  32'h140, 32'h0,   1,  0)); // now taken, alt 0x104
        vecs.push_back(mk(32'h100, 32'h40,  OP_N, OP_B, 1,  0,  0,  0,  0,  1,  32'h140, 32'h104, 0,  0)); // 10->11
        vecs.push_back(mk(32'h100, 32'h40,  OP_B, OP_N, 0,  0,  0,  0,  1,  0,  32'h140, 32'h0,   1,  0));
        vecs.push_back(mk(32'h300, 32'h20,  OP_B, OP_B, 1,  0,  0,  0,  1,  1,  32'h320, 32'h104, 0,  0)); // push+pop
        vecs.push_back(mk(32'h400, 32'h8,   OP_B, OP_B, 1,  0,  0,  0,  1,  1,  32'h408, 32'h304, 0,  0));
        vecs.push_back(mk(32'h500, 32'h8,   OP_B, OP_B, 1,  0,  0,  0,  1,  1,  32'h508, 32'h404, 0,  0)); // saturated at 11
        vecs.push_back(mk(32'h0,   32'h0,   OP_N, OP_B, 0,  0,  0,  0,  0,  0,  32'h0,   32'h504, 0,  1)); // 11->10
        vecs.push_back(mk(32'h100, 32'h40,  OP_B, OP_N, 0,  0,  0,  0,  1,  0,  32'h140, 32'h0,   1,  0)); // still taken
        vecs.push_back(mk(32'h200, 32'h10,  OP_B, OP_N, 0,  0,  0,  0,  1,  0,  32'h210, 32'h104, 0,  0)); // queue full
        vecs.push_back(mk(32'h600, 32'h100, OP_B, OP_B, 0,  0,  0,  1,  1,  0,  32'h700, 32'h104, 0,  1)); // flush, 10->01
        vecs.push_back(mk(32'h100, 32'h40,  OP_B, OP_N, 0,  0,  0,  0,  0,  0,  32'h140, 32'h0,   1,  0)); // emptied, ctr 01
        vecs.push_back(mk(32'h800, 32'h10,  OP_B, OP_B, 1,  0,  1,  0,  0,  1,  32'h810, 32'h140, 0,  1)); // Dstall x3
        vecs.push_back(mk(32'h800, 32'h10,  OP_B, OP_B, 1,  0,  1,  0,  0,  1,  32'h810, 32'h140, 0,  1));
        vecs.push_back(mk(32'h800, 32'h10,  OP_B, OP_B, 1,  0,  1,  0,  0,  1,  32'h810, 32'h140, 0,  1));
        vecs.push_back(mk(32'h100, 32'h40,  OP_J, OP_N, 0,  0,  0,  0,  1,  0,  32'h140, 32'h140, 0,  0)); // J: taken, no push
        vecs.push_back(mk(32'h180, 32'h40,  OP_B, OP_N, 0,  0,  0,  0,  0,  0,  32'h1C0, 32'h140, 0,  0));
        vecs.push_back(mk(32'h100, 32'h40,  OP_N, OP_B, 1,  0,  0,  0,  0,  1,  32'h140, 32'h140, 0,  1)); // 01->10
        vecs.push_back(mk(32'h100, 32'h40,  OP_N, OP_B, 0,  0,  0,  0,  0,  0,  32'h140, 32'h1C0, 0,  0)); // 10->01
        vecs.push_back(mk(32'h100, 32'h40,  OP_N, OP_N, 0,  0,  0,  0,  0,  0,  32'h140, 32'h0,   1,  0));
        vecs.push_back(mk(32'h100, 32'h40,  OP_N, OP_B, 1,  0,  0,  0,  0,  1,  32'h140, 32'h0,   1,  0)); // pop on empty
        vecs.push_back(mk(32'h100, 32'h40,  OP_B, OP_N, 0,  0,  0,  0,  0,  0,  32'h140, 32'h0,   1,  0)); // ctr unchanged

        rst_n = 1'b0;
        drive(32'h100, 32'h40, OP_N, OP_N, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].imm, vecs[i].op_if, vecs[i].op_exe,
                  vecs[i].tk, vecs[i].ist, vecs[i].dst, vecs[i].fl);
            #1;
            chk($sformatf("v%0d taken_sel", i),  32'(taken_sel),  32'(vecs[i].e_ts));
            chk($sformatf("v%0d jump_sel", i),   32'(jump_sel),   32'(vecs[i].e_js));
            chk($sformatf("v%0d PC_imm", i),     PC_imm,          vecs[i].e_pcimm);
            chk($sformatf("v%0d PC_imm_que", i), PC_imm_que,      vecs[i].e_que);
            chk($sformatf("v%0d que_empty", i),  32'(que_empty),  32'(vecs[i].e_empty));
            chk($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(vecs[i].e_mis));
        end

        // Train the counter up to strong-taken, then reset asynchronously mid-stall.
        @(negedge clk);
        drive(32'h100, 32'h40, OP_B, OP_B, 1, 0, 0, 0);
        #1;
        chk("seqA taken_sel", 32'(taken_sel), 32'd0);
        chk("seqA mispredict", 32'(mispredict), 32'd1);
        @(negedge clk);
        drive(32'h100, 32'h40, OP_B, OP_B, 1, 0, 0, 0);
        #1;
        chk("seqB taken_sel", 32'(taken_sel), 32'd1);
        chk("seqB PC_imm_que", PC_imm_que, 32'h140);
        @(negedge clk);
        drive(32'h100, 32'h40, OP_B, OP_N, 0, 0, 1, 0);
        #1;
        chk("seqC taken_sel", 32'(taken_sel), 32'd1);
        chk("seqC PC_imm_que", PC_imm_que, 32'h104);
        chk("seqC que_empty", 32'(que_empty), 32'd0);
        #1;
        rst_n = 1'b0;
        opcode_EXE = OP_B;
        branch_taken_EXE = 1'b0;
        #1;
        chk("arst taken_sel", 32'(taken_sel), 32'd0);
        chk("arst que_empty", 32'(que_empty), 32'd1);
        chk("arst PC_imm_que", PC_imm_que, 32'h0);
        chk("arst mispredict", 32'(mispredict), 32'd0);
        chk("arst jump_sel", 32'(jump_sel), 32'd0);
        chk("arst PC_imm", PC_imm, 32'h140);
        @(negedge clk);
        chk("arst hold que_empty", 32'(que_empty), 32'd1);
        rst_n = 1'b1;
        drive(32'h100, 32'h40, OP_B, OP_N, 0, 0, 0, 0);
        #1;
        chk("post-reset taken_sel", 32'(taken_sel), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
